alarm_vent_driver: RTL and testbench

//  Actuator driver downstream of the activation logic. Consumes the registered Alarma/Ventilacion

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_vent_driver_tick_timer.sv | 42 ++++
 rtl/alarm_vent_driver.sv | 196 +++++++++++++++++++
 tb/tb_alarm_vent_driver.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared constants and state encodings for the alarm/ventilation actuator driver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alarm_pkg;

    // Drive levels for the physical actuators.
    localparam logic ENCENDIDO = 1'b1;
    localparam logic APAGADO   = 1'b0;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_ON   = 2'd1,
        B_OFF  = 2'd2,
        B_SIL  = 2'd3
    } buz_state_e;

    typedef enum logic [1:0] {
        V_OFF  = 2'd0,
        V_ON   = 2'd1,
        V_HOLD = 2'd2
    } vent_state_e;

    // Used to size timers that hold the largest of several tick counts.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_vent_driver_tick_timer.sv
// Down-counting phase timer: load N on phase entry, done pulses on the Nth tick after load.
// Latency: done is combinational from the count flop and tick; load takes effect next clk.
// Backpressure: none; load always wins over a same-cycle tick.
//
// Ports: clk, rst (async, active-high), load/load_val (restart with a new count),
//        tick (prescaler strobe), done (one-cycle pulse, the caller changes phase on it).
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // done must not depend on load: the caller derives load from done.
    assign done = tick && (count_q == W'(1));

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            // Stops at zero, so an idle timer never re-fires.
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alarm_vent_driver.sv
// Actuator driver: pulsed buzzer with user silence, alarm LED, ventilation motor with run-on.
// Latency: every output is a flop; reacts to inputs one clk after they are sampled.
// Backpressure: none; level inputs are consumed every clk, Silenciar is a one-clk pulse.
//
// Ports: clk, rst (async, active-high); Alarma, Ventilacion (request levels);
//        Silenciar (silence pulse); Buzzer, LedAlarma, Motor, Silenciado (registered drives).
module alarm_vent_driver
    import alarm_pkg::*;
#(
    parameter int CLK_PER_TICK    = 100000,
    parameter int BEEP_ON_TICKS   = 500,
    parameter int BEEP_OFF_TICKS  = 500,
    parameter int SILENCE_TICKS   = 30000,
    parameter int VENT_HOLD_TICKS = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic Alarma,
    input  logic Ventilacion,
    input  logic Silenciar,
    output logic Buzzer,
    output logic LedAlarma,
    output logic Motor,
    output logic Silenciado
);

    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int BW = $clog2(max2(max2(BEEP_ON_TICKS, BEEP_OFF_TICKS), SILENCE_TICKS) + 1);
    localparam int VW = $clog2(VENT_HOLD_TICKS + 1);

    // ---------------- prescaler ----------------
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          tick;

    assign tick = (presc_q == PW'(CLK_PER_TICK - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // ---------------- timers ----------------
    logic          b_load;
    logic [BW-1:0] b_load_val;
    logic          b_done;
    logic          v_load;
    logic [VW-1:0] v_load_val;
    logic          v_done;

    tick_timer #(.W(BW)) u_buz_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (b_load),
        .load_val (b_load_val),
        .tick     (tick),
        .done     (b_done)
    );

    tick_timer #(.W(VW)) u_vent_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (v_load),
        .load_val (v_load_val),
        .tick     (tick),
        .done     (v_done)
    );

    // ---------------- buzzer FSM ----------------
    buz_state_e b_state_q;
    buz_state_e b_state_d;

    always_comb begin
        b_state_d  = b_state_q;
        b_load     = 1'b0;
        b_load_val = '0;
        if (!Alarma) begin
            // Dropping the alarm outranks silence and timer end; timer is cleared
            // so a later re-assert starts from a clean, full on-phase.
            b_state_d = B_IDLE;
            b_load    = 1'b1;
        end else begin
            unique case (b_state_q)
                B_IDLE: begin
                    b_state_d  = B_ON;
                    b_load     = 1'b1;
                    b_load_val = BW'(BEEP_ON_TICKS);
                end
                B_ON, B_OFF: begin
                    if (Silenciar) begin
                        b_state_d  = B_SIL;
                        b_load     = 1'b1;
                        b_load_val = BW'(SILENCE_TICKS);
                    end else if (b_done) begin
                        b_state_d  = (b_state_q == B_ON) ? B_OFF : B_ON;
                        b_load     = 1'b1;
                        b_load_val = (b_state_q == B_ON) ? BW'(BEEP_OFF_TICKS)
                                                         : BW'(BEEP_ON_TICKS);
                    end
                end
                B_SIL: begin
                    // A second Silenciar here does not extend the window.
                    if (b_done) begin
                        b_state_d  = B_ON;
                        b_load     = 1'b1;
                        b_load_val = BW'(BEEP_ON_TICKS);
                    end
                end
                default: begin
                    b_state_d = B_IDLE;
                    b_load    = 1'b1;
                end
            endcase
        end
    end

    // ---------------- vent FSM ----------------
    vent_state_e v_state_q;
    vent_state_e v_state_d;

    always_comb begin
        v_state_d  = v_state_q;
        v_load     = 1'b0;
        v_load_val = '0;
        unique case (v_state_q)
            V_OFF: begin
                if (Ventilacion) begin
                    v_state_d = V_ON;
                end
            end
            V_ON: begin
                if (!Ventilacion) begin
                    v_state_d  = V_HOLD;
                    v_load     = 1'b1;
                    v_load_val = VW'(VENT_HOLD_TICKS);
                end
            end
            V_HOLD: begin
                if (Ventilacion) begin
                    // Request came back: discard the pending run-on.
                    v_state_d = V_ON;
                    v_load    = 1'b1;
                end else if (v_done) begin
                    v_state_d = V_OFF;
                end
            end
            default: begin
                v_state_d = V_OFF;
                v_load    = 1'b1;
            end
        endcase
    end

    // ---------------- output decode ----------------
    // Decoded from next state so the registered drives line up with the state flops.
    logic buzzer_d;
    logic buzzer_q;
    logic silenciado_d;
    logic silenciado_q;
    logic motor_d;
    logic motor_q;
    logic led_alarma_d;
    logic led_alarma_q;

    always_comb begin
        buzzer_d     = (b_state_d == B_ON)  ? ENCENDIDO : APAGADO;
        silenciado_d = (b_state_d == B_SIL) ? ENCENDIDO : APAGADO;
        motor_d      = (v_state_d != V_OFF) ? ENCENDIDO : APAGADO;
        led_alarma_d = Alarma;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            b_state_q    <= B_IDLE;
            v_state_q    <= V_OFF;
            buzzer_q     <= APAGADO;
            silenciado_q <= APAGADO;
            motor_q      <= APAGADO;
            led_alarma_q <= APAGADO;
        end else begin
            presc_q      <= presc_d;
            b_state_q    <= b_state_d;
            v_state_q    <= v_state_d;
            buzzer_q     <= buzzer_d;
            silenciado_q <= silenciado_d;
            motor_q      <= motor_d;
            led_alarma_q <= led_alarma_d;
        end
    end

    assign Buzzer     = buzzer_q;
    assign Silenciado = silenciado_q;
    assign Motor      = motor_q;
    assign LedAlarma  = led_alarma_q;

endmodule

// File: tb/tb_alarm_vent_driver.sv
// Directed bench for alarm_vent_driver with small tick counts.
// Latency: edge-indexed histories; edge n is the nth clk after reset release.
// Backpressure: n/a.
module tb_alarm_vent_driver;

    logic clk;
    logic rst;
    logic alarma;
    logic ventilacion;
    logic silenciar;
    logic buzzer;
    logic led_alarma;
    logic motor;
    logic silenciado;

    int n_checks = 0;
    int n_errors = 0;
    int en       = 0;

    // Output value after edge n is stored at bit n; bit 0 holds the reset value.
    logic [63:0] buz_h;
    logic [63:0] led_h;
    logic [63:0] mot_h;
    logic [63:0] sil_h;

    alarm_vent_driver #(
        .CLK_PER_TICK    (4),
        .BEEP_ON_TICKS   (2),
        .BEEP_OFF_TICKS  (3),
        .SILENCE_TICKS   (5),
        .VENT_HOLD_TICKS (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Alarma      (alarma),
        .Ventilacion (ventilacion),
        .Silenciar   (silenciar),
        .Buzzer      (buzzer),
        .LedAlarma   (led_alarma),
        .Motor       (motor),
        .Silenciado  (silenciado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // First edge after 'from' (up to 'last') where the history changes value; -1 if none.
    function automatic int next_change(input logic [63:0] v, input int from, input int last);
        for (int n = from + 1; n <= last; n++) begin
            if (v[n] !== v[n-1]) return n;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        en++;
        buz_h[en] = buzzer;
        led_h[en] = led_alarma;
        mot_h[en] = motor;
        sil_h[en] = silenciado;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        alarma      = 1'b0;
        ventilacion = 1'b0;
        silenciar   = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("reset_state", {28'd0, buzzer, led_alarma, motor, silenciado}, 0);
        buz_h = '0;
        led_h = '0;
        mot_h = '0;
        sil_h = '0;
        en    = 0;
        rst   = 1'b0;
    endtask

    initial begin
        int exp_t[8];
        rst         = 1'b1;
        alarma      = 1'b0;
        ventilacion = 1'b0;
        silenciar   = 1'b0;

        // Idle: 50 clk with inputs low, every output stays low.
        do_reset();
        for (int n = 1; n <= 50; n++) step();
        chk_eq("idle_quiet", 32'((buz_h | led_h | mot_h | sil_h) != 64'd0), 0);

        // Alarm held 60 clk: on 7/8 clk, off 12 clk, repeating; drop at edge 61.
        do_reset();
        alarma = 1'b1;
        for (int n = 1; n <= 60; n++) step();
        alarma = 1'b0;
        step();
        chk_eq("led_follows_alarma", 32'(led_h[1]), 1);
        chk_eq("led_drops", 32'(led_h[61]), 0);
        chk_eq("no_silence_in_beep", 32'($countones(sil_h)), 0);
        exp_t = '{1, 8, 20, 28, 40, 48, 60, 61};
        begin
            int p;
            p = 0;
            for (int k = 0; k < 8; k++) begin
                p = next_change(buz_h, p, en);
                chk_eq($sformatf("beep_edge%0d", k), p, exp_t[k]);
                if (p < 0) break;
            end
        end

        // Silence in B_ON at edge 3, second pulse at edge 10 ignored.
        do_reset();
        alarma = 1'b1;
        for (int n = 1; n <= 26; n++) begin
            silenciar = (n == 3) || (n == 10);
            step();
        end
        silenciar = 1'b0;
        chk_eq("on_before_silence", 32'(buz_h[2]), 1);
        chk_eq("silence_mutes", 32'(buz_h[3]), 0);
        chk_eq("silenciado_set", 32'(sil_h[3]), 1);
        chk_eq("silence_len", 32'($countones(sil_h)), 17);
        chk_eq("silence_end_edge", next_change(sil_h, 3, en), 20);
        chk_eq("buzz_during_sil", 32'($countones(buz_h[19:1])), 2);
        chk_eq("buzz_after_sil", 32'(buz_h[20]), 1);

        // Silence in the same clk the alarm falls, then alarm re-asserted.
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            alarma    = (n <= 3) || (n >= 11);
            silenciar = (n == 4);
            step();
        end
        alarma    = 1'b0;
        silenciar = 1'b0;
        chk_eq("buzz_pre_drop", 32'(buz_h[3]), 1);
        chk_eq("drop_beats_silence", 32'(buz_h[4]), 0);
        chk_eq("no_silenciado", 32'($countones(sil_h)), 0);
        chk_eq("led_drop_same", 32'(led_h[4]), 0);
        chk_eq("idle_before_rearm", 32'(buz_h[10]), 0);
        chk_eq("rearm_on", 32'(buz_h[11]), 1);
        chk_eq("rearm_full_on", next_change(buz_h, 11, en), 16);

        // Vent and alarm rise and fall together: independent behaviour.
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            ventilacion = (n <= 10);
            alarma      = (n <= 10);
            step();
        end
        ventilacion = 1'b0;
        alarma      = 1'b0;
        chk_eq("motor_on", 32'(mot_h[1]), 1);
        chk_eq("buzz_on_with_motor", 32'(buz_h[1]), 1);
        chk_eq("motor_run_on_edge", next_change(mot_h, 1, en), 24);
        chk_eq("motor_len", 32'($countones(mot_h)), 23);
        chk_eq("buzz_off_edge", next_change(buz_h, 1, en), 8);
        chk_eq("buzz_stays_off", next_change(buz_h, 8, en), -1);

        // Vent re-asserted on the 2nd hold tick, then a fresh full hold.
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            ventilacion = (n <= 4) || (n >= 12 && n <= 14);
            step();
        end
        ventilacion = 1'b0;
        chk_eq("motor_no_gap", 32'($countones(mot_h[27:1])), 27);
        chk_eq("motor_rehold_edge", next_change(mot_h, 1, en), 28);

        // Reset asserted mid-hold and mid-silence: immediate clear, no residue.
        do_reset();
        alarma = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            ventilacion = (n <= 4);
            silenciar   = (n == 3);
            step();
        end
        chk_eq("pre_rst_motor", 32'(mot_h[7]), 1);
        chk_eq("pre_rst_sil", 32'(sil_h[7]), 1);
        rst = 1'b1;
        #1;
        chk_eq("async_rst_outs", {28'd0, buzzer, led_alarma, motor, silenciado}, 0);
        do_reset();
        for (int n = 1; n <= 20; n++) step();
        chk_eq("no_residue", 32'($countones(buz_h | led_h | mot_h | sil_h)), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
